// File: rtl/i2s_data_output_if.sv
// Sample handshake between the core and the I2S transmit FIFO.
// The core drives in_data/in_valid; the FIFO returns in_ready.
interface i2s_data_output_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_data_output.sv
// I2S master transmitter: 64-entry sample FIFO feeding a left/right serializer with refill request.
// Optional build macro I2S_MONO_EN: one pop per frame, right slot repeats the left word.
module i2s_data_output #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 6,
    parameter int CLK_DIV    = 2,
    parameter int LOW_WATER  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    i2s_data_output_if.slave      in_if,
    output logic                  bclk_o,
    output logic                  lrclk_o,
    output logic                  sdata_o,
    output logic                  request_o,
    output logic                  underrun_o,
    output logic [ADDR_WIDTH:0]   level_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LEVEL_LOW  = (ADDR_WIDTH + 1)'(LOW_WATER);
    localparam logic [4:0]          LAST_BIT   = 5'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

    state_e                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic                    bclk_q, bclk_d;
    logic                    lrclk_q, lrclk_d;
    logic                    sdata_q, sdata_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    underrun_q, underrun_d;
    logic [ADDR_WIDTH:0]     level_q, level_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic                    request_q;
`ifdef I2S_MONO_EN
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
`endif

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic full, empty, push, pop, tick, frame_end;

    assign full            = (level_q == LEVEL_FULL);
    assign empty           = (level_q == '0);
    assign in_if.in_ready  = !full && !reset;
    assign push            = in_if.in_valid && in_if.in_ready;
    assign tick            = (state_q != IDLE) && (div_q == DIV_LAST);
    // Last falling tick of a stopping frame: return to idle instead of starting a new left slot.
    assign frame_end       = tick && bclk_q && (state_q == STOP) && !enable_i
                             && (bit_cnt_q == 6'd63);

    // NOTE: the sample storage is deliberately left out of reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_if.in_data;
        end
    end

    // NOTE: every variable below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
`ifdef I2S_MONO_EN
        hold_d     = hold_q;
`endif

        case (state_q)
            IDLE:    if (enable_i) state_d = RUN;
            RUN:     if (!enable_i) state_d = STOP;
            STOP:    if (enable_i) state_d = RUN;
                     else if (frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE || frame_end) begin
            div_d     = '0;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            sdata_d   = 1'b0;
            bit_cnt_d = 6'd63;
        end else if (tick) begin
            div_d  = '0;
            bclk_d = !bclk_q;
            if (bclk_q) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                lrclk_d   = bit_cnt_d[5];
                if (bit_cnt_d[4:0] == 5'd0) begin
                    sdata_d = 1'b0;
`ifdef I2S_MONO_EN
                    if (!bit_cnt_d[5]) begin
                        if (empty) begin
                            shift_d    = '0;
                            hold_d     = '0;
                            underrun_d = 1'b1;
                        end else begin
                            shift_d = mem[rd_ptr_q];
                            hold_d  = mem[rd_ptr_q];
                            pop     = 1'b1;
                        end
                    end else begin
                        shift_d = hold_q;
                    end
`else
                    if (empty) begin
                        shift_d    = '0;
                        underrun_d = 1'b1;
                    end else begin
                        shift_d = mem[rd_ptr_q];
                        pop     = 1'b1;
                    end
`endif
                end else if (bit_cnt_d[4:0] <= LAST_BIT) begin
                    sdata_d = shift_q[DATA_WIDTH-1];
                    shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    sdata_d = 1'b0;
                end
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            bit_cnt_q  <= 6'd63;
            shift_q    <= '0;
            underrun_q <= 1'b0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            request_q  <= 1'b1;
`ifdef I2S_MONO_EN
            hold_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            underrun_q <= underrun_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            request_q  <= (level_d < LEVEL_LOW);
`ifdef I2S_MONO_EN
            hold_q     <= hold_d;
`endif
        end
    end

    assign bclk_o     = bclk_q;
    assign lrclk_o    = lrclk_q;
    assign sdata_o    = sdata_q;
    assign request_o  = request_q;
    assign underrun_o = underrun_q;
    assign level_o    = level_q;
endmodule

// File: tb/tb_i2s_data_output.sv
// Directed bench for i2s_data_output (default stereo build, CLK_DIV=2).
// A negedge monitor records bclk timing, the serial bit stream and the words of each slot.
module tb_i2s_data_output;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       bclk, lrclk, sdata, request, underrun;
    logic [6:0] level;

    i2s_data_output_if #(.DATA_WIDTH(24)) in_if ();

    i2s_data_output #(
        .DATA_WIDTH(24), .ADDR_WIDTH(6), .CLK_DIV(2), .LOW_WATER(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable_i   (enable),
        .in_if      (in_if),
        .bclk_o     (bclk),
        .lrclk_o    (lrclk),
        .sdata_o    (sdata),
        .request_o  (request),
        .underrun_o (underrun),
        .level_o    (level)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Monitor: positions are counted from the first bclk fall after arming.
    logic        mon_arm = 1'b0;
    logic        prev_bclk = 1'b0, prev_lr = 1'b0;
    int          mon_cyc, mon_falls, mon_unders, mon_ones;
    int          mon_fall1, mon_fall2, mon_fall65, mon_lr_rise;
    logic [63:0] mon_bits;
    logic [23:0] mon_sh;
    logic [23:0] mon_words [$];

    always @(negedge clk) begin
        prev_bclk <= bclk;
        prev_lr   <= lrclk;
        if (!mon_arm) begin
            mon_cyc     <= 0;
            mon_falls   <= 0;
            mon_unders  <= 0;
            mon_ones    <= 0;
            mon_fall1   <= -1;
            mon_fall2   <= -1;
            mon_fall65  <= -1;
            mon_lr_rise <= -1;
            mon_bits    <= '0;
            mon_sh      <= '0;
            mon_words.delete();
        end else begin
            mon_cyc <= mon_cyc + 1;
            if (underrun) mon_unders <= mon_unders + 1;
            if (sdata)    mon_ones   <= mon_ones + 1;
            if (prev_bclk && !bclk) begin
                mon_falls <= mon_falls + 1;
                if (mon_falls == 0)  mon_fall1  <= mon_cyc;
                if (mon_falls == 1)  mon_fall2  <= mon_cyc;
                if (mon_falls == 64) mon_fall65 <= mon_cyc;
            end
            if (!prev_lr && lrclk && mon_lr_rise < 0) mon_lr_rise <= mon_cyc;
            if (!prev_bclk && bclk && mon_falls > 0) begin
                mon_bits[63 - ((mon_falls - 1) % 64)] <= sdata;
                if (((mon_falls - 1) % 32) >= 1 && ((mon_falls - 1) % 32) <= 24)
                    mon_sh <= {mon_sh[22:0], sdata};
                if (((mon_falls - 1) % 32) == 24)
                    mon_words.push_back({mon_sh[22:0], sdata});
            end
        end
    end

    task automatic tick_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [23:0] w);
        in_if.in_valid = 1'b1;
        in_if.in_data  = w;
        tick_clk(1);
        in_if.in_valid = 1'b0;
    endtask

    task automatic wait_level(input int target, input int budget, input string tag);
        int k = 0;
        while (int'(level) != target && k < budget) begin
            tick_clk(1);
            k++;
        end
        check(tag, level, 64'(target));
    endtask

    task automatic wait_falls(input int n, input int budget, input string tag);
        int k = 0;
        while (mon_falls < n && k < budget) begin
            tick_clk(1);
            k++;
        end
        check(tag, 64'(mon_falls >= n), 64'd1);
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k = 0;
        while (mon_words.size() < n && k < budget) begin
            tick_clk(1);
            k++;
        end
        check(tag, 64'(mon_words.size() >= n), 64'd1);
    endtask

    initial begin
        logic [63:0] exp_frame;

        // Reset held 3 clk with a write offered: nothing may be accepted.
        reset          = 1'b1;
        enable         = 1'b0;
        in_if.in_valid = 1'b1;
        in_if.in_data  = 24'h123456;
        tick_clk(3);
        check("rst_in_ready", in_if.in_ready, 0);
        check("rst_outputs",  {bclk, lrclk, sdata, underrun}, 4'b0000);
        check("rst_level",    level, 0);
        check("rst_request",  request, 1);
        reset          = 1'b0;
        in_if.in_valid = 1'b0;
        tick_clk(1);
        check("post_rst_level", level, 0);

        // Fill 64 words; request falls when level reaches LOW_WATER.
        for (int i = 1; i <= 64; i++) begin
            in_if.in_valid = 1'b1;
            in_if.in_data  = 24'(i);
            tick_clk(1);
            if (i == 31) check("fill_req_31", request, 1);
            if (i == 32) check("fill_req_32", request, 0);
        end
        in_if.in_data = 24'hFFFFFF;
        check("full_in_ready", in_if.in_ready, 0);
        tick_clk(1);
        in_if.in_valid = 1'b0;
        check("full_level",   level, 64);
        check("full_request", request, 0);

        // Drain: request returns below LOW_WATER, then push and pop in the same cycle across the wrap.
        mon_arm = 1'b1;
        enable  = 1'b1;
        wait_level(32, 5000, "drain_to_32");
        check("drain_req_32", request, 0);
        wait_level(31, 300, "drain_to_31");
        check("drain_req_31", request, 1);
        wait_level(5, 4000, "drain_to_5");
        tick_clk(127);
        check("pre_concurrent_level", level, 5);
        in_if.in_valid = 1'b1;
        in_if.in_data  = 24'hC0FFEE;
        tick_clk(1);
        in_if.in_valid = 1'b0;
        check("concurrent_level", level, 5);
        wait_words(65, 1500, "drain_words");
        check("word_0",  mon_words[0],  24'h000001);
        check("word_1",  mon_words[1],  24'h000002);
        check("word_62", mon_words[62], 24'h00003F);
        check("word_63", mon_words[63], 24'h000040);
        check("word_64", mon_words[64], 24'hC0FFEE);
        enable  = 1'b0;
        mon_arm = 1'b0;
        reset   = 1'b1;
        tick_clk(2);
        reset   = 1'b0;

        // Underrun: empty FIFO gives one pulse per slot and a silent line.
        mon_arm = 1'b1;
        enable  = 1'b1;
        wait_falls(64, 600, "underrun_frame");
        check("underrun_pulses", mon_unders, 2);
        check("underrun_sdata",  mon_ones, 0);
        check("underrun_level",  level, 0);
        enable  = 1'b0;
        mon_arm = 1'b0;
        reset   = 1'b1;
        tick_clk(2);
        reset   = 1'b0;

        // Serial frame with stop requested at bit_cnt=10.
        push_word(24'hA5A5A5);
        push_word(24'h5A5A5A);
        push_word(24'h111111);
        push_word(24'h222222);
        check("frame_preload_level", level, 4);
        mon_arm = 1'b1;
        enable  = 1'b1;
        wait_falls(11, 200, "stop_reach_bit10");
        enable  = 1'b0;
        wait_falls(65, 400, "stop_frame_done");
        tick_clk(20);
        exp_frame = {1'b0, 24'hA5A5A5, 7'b0, 1'b0, 24'h5A5A5A, 7'b0};
        check("frame_bits",       mon_bits, exp_frame);
        check("bclk_period",      mon_fall2 - mon_fall1, 4);
        check("frame_period",     mon_fall65 - mon_fall1, 256);
        check("lrclk_rise",       mon_lr_rise - mon_fall1, 128);
        check("stop_no_more_bclk", mon_falls, 65);
        check("stop_idle_outputs", {bclk, lrclk, sdata}, 3'b000);
        check("stop_level",       level, 2);
        check("stop_no_underrun", mon_unders, 0);
        mon_arm = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
